// File: rtl/brightness_ctrl.sv
// brightness_ctrl: debounced up/down keys step a target level; the applied level ramps toward it once per frame.
// Latency: i_vs rise at pin to brightness_cnt change 3 clk; key press accepted DEB_CYCLES clk after sync.
// Backpressure: none. Optional AUTO_REPEAT_EN adds periodic repeat while a key stays held.

module brightness_key_deb #(
   parameter logic [19:0] DEB_CYCLES    = 20'd1_000_000,
   parameter logic [23:0] REPEAT_CYCLES = 24'd10_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic press,
   output logic held
);

   typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} deb_state_t;

   deb_state_t  state, state_nxt;
   logic        key_s1, key_s2;
   logic [19:0] cnt, cnt_nxt;
   logic        deb_press;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_s1 <= 1'b1;
         key_s2 <= 1'b1;
      end else begin
         key_s1 <= key_n;
         key_s2 <= key_s1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      deb_press = 1'b0;
      case (state)
         IDLE: begin
            if (!key_s2) begin
               state_nxt = PRESS_CHK;
               cnt_nxt   = '0;
            end
         end
         PRESS_CHK: begin
            if (key_s2) begin
               state_nxt = IDLE;
            end else if (cnt == DEB_CYCLES - 20'd1) begin
               state_nxt = HELD;
               deb_press = 1'b1;
            end else begin
               cnt_nxt = cnt + 20'd1;
            end
         end
         HELD: begin
            if (key_s2) begin
               state_nxt = REL_CHK;
               cnt_nxt   = '0;
            end
         end
         REL_CHK: begin
            if (!key_s2) begin
               state_nxt = HELD;
            end else if (cnt == DEB_CYCLES - 20'd1) begin
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt + 20'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign held = (state == HELD);

`ifdef AUTO_REPEAT_EN
   logic [23:0] rep_cnt;
   logic        rep_fire;

   // Repeat only while still physically held, so a release in progress never fires.
   assign rep_fire = held && !key_s2 && (rep_cnt == REPEAT_CYCLES - 24'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_cnt <= '0;
      end else if (!held || rep_fire) begin
         rep_cnt <= '0;
      end else begin
         rep_cnt <= rep_cnt + 24'd1;
      end
   end

   assign press = deb_press | rep_fire;
`else
   logic unused_repeat;
   assign unused_repeat = ^REPEAT_CYCLES;
   assign press         = deb_press;
`endif

endmodule

module brightness_ctrl #(
   parameter logic [19:0] DEB_CYCLES    = 20'd1_000_000,
   parameter logic [7:0]  KEY_STEP      = 8'd10,
   parameter logic [7:0]  RAMP_STEP     = 8'd2,
   parameter logic [7:0]  LVL_MAX       = 8'd200,
   parameter logic [7:0]  LVL_INIT      = 8'd100,
   parameter logic [23:0] REPEAT_CYCLES = 24'd10_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_up_n,
   input  logic       key_dn_n,
   input  logic       i_vs,
   output logic [7:0] brightness_cnt,
   output logic [7:0] target_lvl,
   output logic       ramping,
   output logic       key_evt
);

   logic       up_press, up_held, dn_press, dn_held;
   logic       vs_s1, vs_s2, vs_d, vs_rise;
   logic       up_ok, dn_ok;
   logic [8:0] tgt_up;
   logic [7:0] tgt_dn;
   logic [7:0] tgt_nxt, bcnt_nxt;
   logic [8:0] diff, ramp_sum;

   brightness_key_deb #(
      .DEB_CYCLES    (DEB_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
   ) u_deb_up (
      .clk   (clk),
      .rst_n (rst_n),
      .key_n (key_up_n),
      .press (up_press),
      .held  (up_held)
   );

   brightness_key_deb #(
      .DEB_CYCLES    (DEB_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
   ) u_deb_dn (
      .clk   (clk),
      .rst_n (rst_n),
      .key_n (key_dn_n),
      .press (dn_press),
      .held  (dn_held)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_s1 <= 1'b0;
         vs_s2 <= 1'b0;
         vs_d  <= 1'b0;
      end else begin
         vs_s1 <= i_vs;
         vs_s2 <= vs_s1;
         vs_d  <= vs_s2;
      end
   end

   assign vs_rise = vs_s2 & ~vs_d;

   // A press is dropped when both fire together or the other key is already held.
   always_comb begin
      up_ok   = up_press & ~dn_press & ~dn_held;
      dn_ok   = dn_press & ~up_press & ~up_held;
      tgt_up  = {1'b0, target_lvl} + {1'b0, KEY_STEP};
      tgt_dn  = target_lvl - KEY_STEP;
      tgt_nxt = target_lvl;
      if (up_ok) begin
         tgt_nxt = (tgt_up > {1'b0, LVL_MAX}) ? LVL_MAX : tgt_up[7:0];
      end else if (dn_ok) begin
         tgt_nxt = (target_lvl < KEY_STEP) ? 8'd0 : tgt_dn;
      end
   end

   // Ramp reads the registered target, so a same-cycle key update lands next frame.
   always_comb begin
      bcnt_nxt = brightness_cnt;
      ramp_sum = {1'b0, brightness_cnt} + {1'b0, RAMP_STEP};
      if (target_lvl >= brightness_cnt) begin
         diff = {1'b0, target_lvl} - {1'b0, brightness_cnt};
      end else begin
         diff = {1'b0, brightness_cnt} - {1'b0, target_lvl};
      end
      if (vs_rise) begin
         if (diff <= {1'b0, RAMP_STEP}) begin
            bcnt_nxt = target_lvl;
         end else if (target_lvl > brightness_cnt) begin
            bcnt_nxt = (ramp_sum > {1'b0, LVL_MAX}) ? LVL_MAX : ramp_sum[7:0];
         end else begin
            bcnt_nxt = brightness_cnt - RAMP_STEP;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         brightness_cnt <= LVL_INIT;
         target_lvl     <= LVL_INIT;
         ramping        <= 1'b0;
         key_evt        <= 1'b0;
      end else begin
         brightness_cnt <= bcnt_nxt;
         target_lvl     <= tgt_nxt;
         ramping        <= (bcnt_nxt != tgt_nxt);
         key_evt        <= up_ok | dn_ok;
      end
   end

endmodule

// File: tb/tb_brightness_ctrl.sv
// Directed bench for brightness_ctrl with short debounce/repeat periods.
module tb_brightness_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       key_up_n = 1'b1;
   logic       key_dn_n = 1'b1;
   logic       i_vs = 1'b0;
   logic [7:0] brightness_cnt;
   logic [7:0] target_lvl;
   logic       ramping;
   logic       key_evt;

   int checks = 0;
   int failures = 0;
   int evt_cnt = 0;

   brightness_ctrl #(
      .DEB_CYCLES    (20'd4),
      .KEY_STEP      (8'd10),
      .RAMP_STEP     (8'd2),
      .LVL_MAX       (8'd200),
      .LVL_INIT      (8'd100),
      .REPEAT_CYCLES (24'd16)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .key_up_n       (key_up_n),
      .key_dn_n       (key_dn_n),
      .i_vs           (i_vs),
      .brightness_cnt (brightness_cnt),
      .target_lvl     (target_lvl),
      .ramping        (ramping),
      .key_evt        (key_evt)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (key_evt === 1'b1) evt_cnt++;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press_keys(input logic up, input logic dn, input int low_n);
      if (up) key_up_n = 1'b0;
      if (dn) key_dn_n = 1'b0;
      tick(low_n);
      key_up_n = 1'b1;
      key_dn_n = 1'b1;
      tick(10);
   endtask

   task automatic vs_pulse();
      i_vs = 1'b1;
      tick(3);
      i_vs = 1'b0;
      tick(3);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(2);
   endtask

   task automatic test_reset();
      tick(3);
      checks++; if (brightness_cnt !== 8'd100) begin failures++; $display("FAIL reset_bcnt got=%0d exp=100", brightness_cnt); end
      checks++; if (target_lvl !== 8'd100) begin failures++; $display("FAIL reset_target got=%0d exp=100", target_lvl); end
      checks++; if (ramping !== 1'b0) begin failures++; $display("FAIL reset_ramping got=%b exp=0", ramping); end
      checks++; if (key_evt !== 1'b0) begin failures++; $display("FAIL reset_key_evt got=%b exp=0", key_evt); end
      rst_n = 1'b1;
      tick(2);
   endtask

   task automatic test_glitch_and_ramp();
      int e0;
      e0 = evt_cnt;
      key_up_n = 1'b0;
      tick(2);
      key_up_n = 1'b1;
      tick(12);
      checks++; if (evt_cnt - e0 !== 0) begin failures++; $display("FAIL glitch_evt got=%0d exp=0", evt_cnt - e0); end
      checks++; if (target_lvl !== 8'd100) begin failures++; $display("FAIL glitch_target got=%0d exp=100", target_lvl); end
      press_keys(1'b1, 1'b0, 10);
      checks++; if (evt_cnt - e0 !== 1) begin failures++; $display("FAIL press_evt got=%0d exp=1", evt_cnt - e0); end
      checks++; if (target_lvl !== 8'd110) begin failures++; $display("FAIL press_target got=%0d exp=110", target_lvl); end
      checks++; if (brightness_cnt !== 8'd100) begin failures++; $display("FAIL press_bcnt_hold got=%0d exp=100", brightness_cnt); end
      checks++; if (ramping !== 1'b1) begin failures++; $display("FAIL press_ramping got=%b exp=1", ramping); end
      for (int i = 1; i <= 5; i++) begin
         vs_pulse();
         checks++;
         if (brightness_cnt !== 8'(100 + 2 * i)) begin
            failures++; $display("FAIL ramp_bcnt frame=%0d got=%0d exp=%0d", i, brightness_cnt, 100 + 2 * i);
         end
         checks++;
         if (ramping !== (i < 5)) begin
            failures++; $display("FAIL ramp_flag frame=%0d got=%b exp=%b", i, ramping, (i < 5));
         end
      end
   endtask

   task automatic test_saturation();
      int e0;
      e0 = evt_cnt;
      repeat (12) press_keys(1'b1, 1'b0, 8);
      checks++; if (target_lvl !== 8'd200) begin failures++; $display("FAIL sat_up_target got=%0d exp=200", target_lvl); end
      checks++; if (evt_cnt - e0 !== 12) begin failures++; $display("FAIL sat_up_evt got=%0d exp=12", evt_cnt - e0); end
      checks++; if (brightness_cnt !== 8'd110) begin failures++; $display("FAIL sat_bcnt_hold got=%0d exp=110", brightness_cnt); end
      e0 = evt_cnt;
      repeat (25) press_keys(1'b0, 1'b1, 8);
      checks++; if (target_lvl !== 8'd0) begin failures++; $display("FAIL sat_dn_target got=%0d exp=0", target_lvl); end
      checks++; if (evt_cnt - e0 !== 25) begin failures++; $display("FAIL sat_dn_evt got=%0d exp=25", evt_cnt - e0); end
      vs_pulse();
      checks++; if (brightness_cnt !== 8'd108) begin failures++; $display("FAIL ramp_down got=%0d exp=108", brightness_cnt); end
      checks++; if (ramping !== 1'b1) begin failures++; $display("FAIL ramp_down_flag got=%b exp=1", ramping); end
   endtask

   task automatic test_frame_align();
      do_reset();
      press_keys(1'b1, 1'b0, 8);
      tick(20);
      checks++; if (target_lvl !== 8'd110) begin failures++; $display("FAIL frame_target got=%0d exp=110", target_lvl); end
      checks++; if (brightness_cnt !== 8'd100) begin failures++; $display("FAIL frame_midframe got=%0d exp=100", brightness_cnt); end
      i_vs = 1'b1;
      tick(2);
      checks++; if (brightness_cnt !== 8'd100) begin failures++; $display("FAIL frame_lat2 got=%0d exp=100", brightness_cnt); end
      tick(1);
      checks++; if (brightness_cnt !== 8'd102) begin failures++; $display("FAIL frame_lat3 got=%0d exp=102", brightness_cnt); end
      i_vs = 1'b0;
      tick(3);
   endtask

   task automatic test_both_keys();
      int e0;
      e0 = evt_cnt;
      press_keys(1'b1, 1'b1, 8);
      checks++; if (evt_cnt - e0 !== 0) begin failures++; $display("FAIL both_evt got=%0d exp=0", evt_cnt - e0); end
      checks++; if (target_lvl !== 8'd110) begin failures++; $display("FAIL both_target got=%0d exp=110", target_lvl); end
      // Down held first; the later up press must be ignored.
      e0 = evt_cnt;
      key_dn_n = 1'b0;
      tick(8);
      key_up_n = 1'b0;
      tick(8);
      key_up_n = 1'b1;
      key_dn_n = 1'b1;
      tick(10);
      checks++; if (evt_cnt - e0 !== 1) begin failures++; $display("FAIL conflict_evt got=%0d exp=1", evt_cnt - e0); end
      checks++; if (target_lvl !== 8'd100) begin failures++; $display("FAIL conflict_target got=%0d exp=100", target_lvl); end
   endtask

   task automatic test_reset_mid_ramp();
      do_reset();
      repeat (5) press_keys(1'b1, 1'b0, 8);
      repeat (10) vs_pulse();
      checks++; if (target_lvl !== 8'd150) begin failures++; $display("FAIL midramp_target got=%0d exp=150", target_lvl); end
      checks++; if (brightness_cnt !== 8'd120) begin failures++; $display("FAIL midramp_bcnt got=%0d exp=120", brightness_cnt); end
      #3;
      rst_n = 1'b0;
      #1;
      checks++; if (brightness_cnt !== 8'd100) begin failures++; $display("FAIL arst_bcnt got=%0d exp=100", brightness_cnt); end
      checks++; if (target_lvl !== 8'd100) begin failures++; $display("FAIL arst_target got=%0d exp=100", target_lvl); end
      checks++; if (ramping !== 1'b0) begin failures++; $display("FAIL arst_ramping got=%b exp=0", ramping); end
      tick(2);
      rst_n = 1'b1;
      tick(2);
   endtask

   task automatic test_auto_repeat();
      int  e0;
      int  exp_evt;
      logic [7:0] exp_tgt;
      bit  seen;
`ifdef AUTO_REPEAT_EN
      exp_evt = 4;
      exp_tgt = 8'd140;
`else
      exp_evt = 1;
      exp_tgt = 8'd110;
`endif
      e0 = evt_cnt;
      seen = 1'b0;
      key_up_n = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         tick(1);
         if (key_evt === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen) begin failures++; $display("FAIL repeat_first_press got=none exp=key_evt within 30 cycles"); end
      tick(60);
      key_up_n = 1'b1;
      tick(12);
      checks++; if (evt_cnt - e0 !== exp_evt) begin failures++; $display("FAIL repeat_evt got=%0d exp=%0d", evt_cnt - e0, exp_evt); end
      checks++; if (target_lvl !== exp_tgt) begin failures++; $display("FAIL repeat_target got=%0d exp=%0d", target_lvl, exp_tgt); end
   endtask

   initial begin
      test_reset();
      test_glitch_and_ramp();
      test_saturation();
      test_frame_align();
      test_both_keys();
      test_reset_mid_ramp();
      test_auto_repeat();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
